// File: rtl/axi_wr_mem_slave.sv
// AXI4 write-path endpoint: one AW burst at a time, one SRAM write per W beat, single B response.
// Optional WRAP burst support is enabled by defining AXI_WR_MEM_SLAVE_WRAP_EN; otherwise WRAP bursts are drained with SLVERR.
module axi_wr_mem_slave #(
  parameter int unsigned AXI_ADDR_WIDTH = 32,
  parameter int unsigned AXI_DATA_WIDTH = 64,
  parameter int unsigned AXI_ID_WIDTH   = 4,
  parameter int unsigned AXI_USER_WIDTH = 1
) (
  input  logic                          clk_i,
  input  logic                          rst_ni,
  input  logic [AXI_ID_WIDTH-1:0]       slv_aw_id,
  input  logic [AXI_ADDR_WIDTH-1:0]     slv_aw_addr,
  input  logic [7:0]                    slv_aw_len,
  input  logic [2:0]                    slv_aw_size,
  input  logic [1:0]                    slv_aw_burst,
  input  logic                          slv_aw_lock,
  input  logic [3:0]                    slv_aw_cache,
  input  logic [2:0]                    slv_aw_prot,
  input  logic [3:0]                    slv_aw_qos,
  input  logic [3:0]                    slv_aw_region,
  input  logic [5:0]                    slv_aw_atop,
  input  logic [AXI_USER_WIDTH-1:0]     slv_aw_user,
  input  logic                          slv_aw_valid,
  output logic                          slv_aw_ready,
  input  logic [AXI_DATA_WIDTH-1:0]     slv_w_data,
  input  logic [AXI_DATA_WIDTH/8-1:0]   slv_w_strb,
  input  logic                          slv_w_last,
  input  logic [AXI_USER_WIDTH-1:0]     slv_w_user,
  input  logic                          slv_w_valid,
  output logic                          slv_w_ready,
  output logic [AXI_ID_WIDTH-1:0]       slv_b_id,
  output logic [1:0]                    slv_b_resp,
  output logic [AXI_USER_WIDTH-1:0]     slv_b_user,
  output logic                          slv_b_valid,
  input  logic                          slv_b_ready,
  input  logic [AXI_ID_WIDTH-1:0]       slv_ar_id,
  input  logic [AXI_ADDR_WIDTH-1:0]     slv_ar_addr,
  input  logic [7:0]                    slv_ar_len,
  input  logic [2:0]                    slv_ar_size,
  input  logic [1:0]                    slv_ar_burst,
  input  logic                          slv_ar_lock,
  input  logic [3:0]                    slv_ar_cache,
  input  logic [2:0]                    slv_ar_prot,
  input  logic [3:0]                    slv_ar_qos,
  input  logic [3:0]                    slv_ar_region,
  input  logic [AXI_USER_WIDTH-1:0]     slv_ar_user,
  input  logic                          slv_ar_valid,
  output logic                          slv_ar_ready,
  output logic [AXI_ID_WIDTH-1:0]       slv_r_id,
  output logic [AXI_DATA_WIDTH-1:0]     slv_r_data,
  output logic [1:0]                    slv_r_resp,
  output logic                          slv_r_last,
  output logic [AXI_USER_WIDTH-1:0]     slv_r_user,
  output logic                          slv_r_valid,
  input  logic                          slv_r_ready,
  output logic                          mem_req_o,
  input  logic                          mem_gnt_i,
  output logic [AXI_ADDR_WIDTH-1:0]     mem_addr_o,
  output logic [AXI_DATA_WIDTH-1:0]     mem_wdata_o,
  output logic [AXI_DATA_WIDTH/8-1:0]   mem_be_o
);

  localparam int unsigned STRB_W = AXI_DATA_WIDTH / 8;
  localparam logic [2:0] MAX_SIZE = 3'($clog2(STRB_W));
  localparam logic [AXI_ADDR_WIDTH-1:0] BUS_MASK = ~AXI_ADDR_WIDTH'(STRB_W - 1);
  localparam logic [AXI_ADDR_WIDTH-1:0] ADDR_ONE = AXI_ADDR_WIDTH'(1);

  typedef enum logic [1:0] {IDLE, DATA, RESP} state_t;

  state_t                       state;
  logic [AXI_ID_WIDTH-1:0]      id_q;
  logic [AXI_USER_WIDTH-1:0]    user_q;
  logic [AXI_ADDR_WIDTH-1:0]    addr_q;
  logic [7:0]                   len_q;
  logic [2:0]                   size_q;
  logic [1:0]                   burst_q;
  logic [7:0]                   beat_cnt;
  logic                         err_q;
  logic                         drain_q;

  logic                         aw_hs;
  logic                         w_hs;
  logic                         last_beat;
  logic                         aw_drain;
  logic [AXI_ADDR_WIDTH-1:0]    bsz;
  logic [AXI_ADDR_WIDTH-1:0]    incr_addr;
  logic [AXI_ADDR_WIDTH-1:0]    next_addr;

  assign aw_hs     = slv_aw_valid & slv_aw_ready;
  assign w_hs      = slv_w_valid & slv_w_ready;
  assign last_beat = (beat_cnt == len_q);

  // Bursts the memory cannot honour are still fully accepted but never written.
  always_comb begin
    aw_drain = (slv_aw_size > MAX_SIZE) | (slv_aw_burst == 2'b11) | (slv_aw_atop != '0);
`ifdef AXI_WR_MEM_SLAVE_WRAP_EN
    if (slv_aw_burst == 2'b10) begin
      if (!(slv_aw_len inside {8'd1, 8'd3, 8'd7, 8'd15}) ||
          ((slv_aw_addr & ((ADDR_ONE << slv_aw_size) - ADDR_ONE)) != '0)) begin
        aw_drain = 1'b1;
      end
    end
`else
    if (slv_aw_burst == 2'b10) begin
      aw_drain = 1'b1;
    end
`endif
  end

  always_comb begin
    bsz       = ADDR_ONE << size_q;
    incr_addr = (addr_q & ~(bsz - ADDR_ONE)) + bsz;
    next_addr = incr_addr;
    case (burst_q)
      2'b00: next_addr = addr_q;
`ifdef AXI_WR_MEM_SLAVE_WRAP_EN
      2'b10: begin
        // (len+1)*bsz-1 is built by shift/OR since len+1 is a power of two here.
        logic [AXI_ADDR_WIDTH-1:0] wrap_mask;
        logic [AXI_ADDR_WIDTH-1:0] wrap_base;
        wrap_mask = (AXI_ADDR_WIDTH'(len_q) << size_q) | (bsz - ADDR_ONE);
        wrap_base = addr_q & ~wrap_mask;
        if (incr_addr == wrap_base + wrap_mask + ADDR_ONE) begin
          next_addr = wrap_base;
        end
      end
`endif
      default: ;
    endcase
  end

  // Memory request and W acceptance track the grant combinationally so a beat lands in one cycle.
  always_comb begin
    slv_w_ready = 1'b0;
    mem_req_o   = 1'b0;
    if (state == DATA) begin
      if (drain_q) begin
        slv_w_ready = 1'b1;
      end else begin
        slv_w_ready = mem_gnt_i;
        mem_req_o   = slv_w_valid;
      end
    end
  end

  assign mem_addr_o  = addr_q & BUS_MASK;
  assign mem_wdata_o = slv_w_data;
  assign mem_be_o    = slv_w_strb;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state        <= IDLE;
      slv_aw_ready <= 1'b0;
      slv_b_valid  <= 1'b0;
      slv_b_id     <= '0;
      slv_b_resp   <= 2'b00;
      slv_b_user   <= '0;
      id_q         <= '0;
      user_q       <= '0;
      addr_q       <= '0;
      len_q        <= '0;
      size_q       <= '0;
      burst_q      <= '0;
      beat_cnt     <= '0;
      err_q        <= 1'b0;
      drain_q      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (aw_hs) begin
            id_q         <= slv_aw_id;
            user_q       <= slv_aw_user;
            addr_q       <= slv_aw_addr;
            len_q        <= slv_aw_len;
            size_q       <= slv_aw_size;
            burst_q      <= slv_aw_burst;
            drain_q      <= aw_drain;
            beat_cnt     <= '0;
            err_q        <= 1'b0;
            slv_aw_ready <= 1'b0;
            state        <= DATA;
          end else begin
            slv_aw_ready <= 1'b1;
          end
        end
        DATA: begin
          if (w_hs) begin
            beat_cnt <= beat_cnt + 8'd1;
            addr_q   <= next_addr;
            if (slv_w_last != last_beat) begin
              err_q <= 1'b1;
            end
            if (last_beat) begin
              slv_b_valid <= 1'b1;
              slv_b_id    <= id_q;
              slv_b_user  <= user_q;
              slv_b_resp  <= (err_q | drain_q | !slv_w_last) ? 2'b10 : 2'b00;
              state       <= RESP;
            end
          end
        end
        RESP: begin
          if (slv_b_ready) begin
            slv_b_valid  <= 1'b0;
            slv_aw_ready <= 1'b1;
            state        <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Reads are served elsewhere; the read channel is permanently idle.
  assign slv_ar_ready = 1'b0;
  assign slv_r_id     = '0;
  assign slv_r_data   = '0;
  assign slv_r_resp   = 2'b00;
  assign slv_r_last   = 1'b0;
  assign slv_r_user   = '0;
  assign slv_r_valid  = 1'b0;

  logic unused_inputs;
  assign unused_inputs = ^{slv_aw_lock, slv_aw_cache, slv_aw_prot, slv_aw_qos, slv_aw_region,
                           slv_w_user, slv_ar_id, slv_ar_addr, slv_ar_len, slv_ar_size,
                           slv_ar_burst, slv_ar_lock, slv_ar_cache, slv_ar_prot, slv_ar_qos,
                           slv_ar_region, slv_ar_user, slv_ar_valid, slv_r_ready};

endmodule
